// File: rtl/video_timing_if.sv
// Video timing signal bundle: machine select and strobe in, counters and decodes out.
package video_timing_pkg;
    typedef enum logic [1:0] {
        S48      = 2'd0,
        S128     = 2'd1,
        S3       = 2'd2,
        PENTAGON = 2'd3
    } machine_t;
endpackage

interface video_timing_if;
    import video_timing_pkg::*;

    logic       ck7;
    machine_t   machine;
    logic [8:0] hc;
    logic [8:0] vc;
    logic       screen_contention;
    logic       blank;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;

    modport master (
        input  ck7, machine,
        output hc, vc, screen_contention, blank, hsync, vsync, line_start, frame_start
    );

    modport slave (
        output ck7, machine,
        input  hc, vc, screen_contention, blank, hsync, vsync, line_start, frame_start
    );
endinterface

// File: rtl/video_timing.sv
// Spectrum-family raster timing: pixel/line counters per machine type, ULA
// contention window, blanking, syncs and line/frame start pulses.
module video_timing
    import video_timing_pkg::*;
#(
    parameter logic [8:0] CONT_HSTART  = 9'd0,
    parameter logic [8:0] HBLANK_START = 9'd320,
    parameter logic [8:0] HBLANK_LEN   = 9'd96
) (
    input  logic            clk28,
    input  logic            rst,
    video_timing_if.master  vid
);

    machine_t   machine_q, machine_d;
    logic [8:0] hc_q, hc_d;
    logic [8:0] vc_q, vc_d;
    logic       cont_q, cont_d;
    logic       blank_q, blank_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;

    logic [8:0] line_len;
    logic [8:0] frame_len;
    logic       hc_last;
    logic       vc_last;
    logic [8:0] cont_off;
    logic [8:0] cont_end;
    logic [8:0] hblank_end;

    // Line and frame geometry of the currently latched machine
    always_comb begin
        line_len  = 9'd448;
        frame_len = 9'd312;
        case (machine_q)
            S128, S3: begin
                line_len  = 9'd456;
                frame_len = 9'd311;
            end
            PENTAGON: frame_len = 9'd320;
            default: ;
        endcase
    end

    // ">=" rather than "==" so an out-of-range count still wraps
    assign hc_last = (hc_q >= line_len - 9'd1);
    assign vc_last = (vc_q >= frame_len - 9'd1);

    // Counter advance, wrap, pulse generation and frame-boundary machine latch
    always_comb begin
        hc_d      = hc_q;
        vc_d      = vc_q;
        machine_d = machine_q;
        ls_d      = 1'b0;
        fs_d      = 1'b0;
        if (vid.ck7) begin
            if (hc_last) begin
                hc_d = '0;
                ls_d = 1'b1;
                if (vc_last) begin
                    vc_d      = '0;
                    fs_d      = 1'b1;
                    machine_d = vid.machine;
                end else begin
                    vc_d = vc_q + 9'd1;
                end
            end else begin
                hc_d = hc_q + 9'd1;
                if (vc_q >= frame_len) begin
                    vc_d = '0;
                end
            end
        end
    end

    assign cont_off   = hc_d - CONT_HSTART;
    assign cont_end   = CONT_HSTART + 9'd256;
    assign hblank_end = HBLANK_START + HBLANK_LEN;

    // Decodes evaluated on the next counter values so they line up with hc/vc
    always_comb begin
        cont_d  = (machine_d != PENTAGON) && (vc_d < 9'd192) &&
                  (hc_d >= CONT_HSTART) && (hc_d < cont_end) &&
                  (cont_off[3:2] != 2'b11);
        blank_d = ((hc_d >= HBLANK_START) && (hc_d < hblank_end)) ||
                  ((vc_d >= 9'd240) && (vc_d < 9'd272));
        hsync_d = (hc_d >= 9'd344) && (hc_d < 9'd376);
        vsync_d = (vc_d >= 9'd248) && (vc_d < 9'd252);
    end

    // State and output registers; level outputs move only on ck7 edges
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            machine_q <= vid.machine;
            hc_q      <= '0;
            vc_q      <= '0;
            cont_q    <= 1'b0;
            blank_q   <= 1'b0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            ls_q      <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            machine_q <= machine_d;
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            ls_q      <= ls_d;
            fs_q      <= fs_d;
            if (vid.ck7) begin
                cont_q  <= cont_d;
                blank_q <= blank_d;
                hsync_q <= hsync_d;
                vsync_q <= vsync_d;
            end
        end
    end

    assign vid.hc                = hc_q;
    assign vid.vc                = vc_q;
    assign vid.screen_contention = cont_q;
    assign vid.blank             = blank_q;
    assign vid.hsync             = hsync_q;
    assign vid.vsync             = vsync_q;
    assign vid.line_start        = ls_q;
    assign vid.frame_start       = fs_q;

endmodule

// File: tb/tb_video_timing.sv
// Directed bench for video_timing: raster walk over three machine frames with
// a point table of expected decodes, plus reset and strobe sequences.
`timescale 1ns/1ps
module tb_video_timing;
    import video_timing_pkg::*;

    typedef struct {
        int   vc;
        int   hc;
        logic cont;
        logic blank;
        logic hsync;
        logic vsync;
        int   set_m;
    } pt_t;

    logic clk28 = 1'b0;
    logic rst;

    always #5 clk28 = ~clk28;

    video_timing_if vif();

    video_timing #(
        .CONT_HSTART (9'd0),
        .HBLANK_START(9'd320),
        .HBLANK_LEN  (9'd96)
    ) dut (
        .clk28(clk28),
        .rst  (rst),
        .vid  (vif.master)
    );

    int total = 0;
    int bad   = 0;

    int edges, last_fs_edge, fs_period;
    int hc_max, vc_max, fs_cnt, ls_cnt, cont_cnt;

    pt_t tab48[$];
    pt_t tab128[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        hc_max   = 0;
        vc_max   = 0;
        ls_cnt   = 0;
        cont_cnt = 0;
    endtask

    task automatic step();
        @(posedge clk28);
        #1;
        edges++;
        if (int'(vif.hc) > hc_max) hc_max = int'(vif.hc);
        if (int'(vif.vc) > vc_max) vc_max = int'(vif.vc);
        if (vif.line_start) ls_cnt++;
        if (vif.screen_contention) cont_cnt++;
        if (vif.frame_start) begin
            fs_cnt++;
            fs_period    = edges - last_fs_edge;
            last_fs_edge = edges;
        end
    endtask

    task automatic seek(input int v, input int h);
        int n = 0;
        while ((int'(vif.hc) != h || int'(vif.vc) != v) && n < 200000) begin
            step();
            n++;
        end
        check($sformatf("seek v%0d h%0d", v, h),
              int'(int'(vif.hc) == h && int'(vif.vc) == v), 1);
    endtask

    task automatic run_table(input string tag, input pt_t t[$]);
        for (int i = 0; i < t.size(); i++) begin
            seek(t[i].vc, t[i].hc);
            check($sformatf("%s v%0d h%0d cont", tag, t[i].vc, t[i].hc), vif.screen_contention, t[i].cont);
            check($sformatf("%s v%0d h%0d blank", tag, t[i].vc, t[i].hc), vif.blank, t[i].blank);
            check($sformatf("%s v%0d h%0d hsync", tag, t[i].vc, t[i].hc), vif.hsync, t[i].hsync);
            check($sformatf("%s v%0d h%0d vsync", tag, t[i].vc, t[i].hc), vif.vsync, t[i].vsync);
            if (t[i].set_m >= 0) vif.machine = machine_t'(t[i].set_m);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " hc"}, vif.hc, 0);
        check({tag, " vc"}, vif.vc, 0);
        check({tag, " cont"}, vif.screen_contention, 0);
        check({tag, " blank"}, vif.blank, 0);
        check({tag, " hsync"}, vif.hsync, 0);
        check({tag, " vsync"}, vif.vsync, 0);
        check({tag, " line_start"}, vif.line_start, 0);
        check({tag, " frame_start"}, vif.frame_start, 0);
    endtask

    initial begin
        // S48 frame points; 12 contended / 4 free per 16 hc on active lines
        for (int h = 0; h <= 20; h++)
            tab48.push_back('{10, h, (h < 12 || h > 15), 1'b0, 1'b0, 1'b0, -1});
        tab48.push_back('{10, 251, 1'b1, 1'b0, 1'b0, 1'b0, -1});
        tab48.push_back('{10, 255, 1'b0, 1'b0, 1'b0, 1'b0, -1});
        tab48.push_back('{10, 256, 1'b0, 1'b0, 1'b0, 1'b0, -1});
        tab48.push_back('{10, 319, 1'b0, 1'b0, 1'b0, 1'b0, -1});
        tab48.push_back('{10, 320, 1'b0, 1'b1, 1'b0, 1'b0, -1});
        tab48.push_back('{10, 343, 1'b0, 1'b1, 1'b0, 1'b0, -1});
        tab48.push_back('{10, 344, 1'b0, 1'b1, 1'b1, 1'b0, -1});
        tab48.push_back('{10, 375, 1'b0, 1'b1, 1'b1, 1'b0, -1});
        tab48.push_back('{10, 376, 1'b0, 1'b1, 1'b0, 1'b0, -1});
        tab48.push_back('{10, 415, 1'b0, 1'b1, 1'b0, 1'b0, -1});
        tab48.push_back('{10, 416, 1'b0, 1'b0, 1'b0, 1'b0, -1});
        tab48.push_back('{100, 0, 1'b1, 1'b0, 1'b0, 1'b0, int'(S128)});
        tab48.push_back('{191, 5, 1'b1, 1'b0, 1'b0, 1'b0, -1});
        for (int h = 0; h <= 20; h++)
            tab48.push_back('{192, h, 1'b0, 1'b0, 1'b0, 1'b0, -1});
        tab48.push_back('{239, 0, 1'b0, 1'b0, 1'b0, 1'b0, -1});
        tab48.push_back('{240, 0, 1'b0, 1'b1, 1'b0, 1'b0, -1});
        tab48.push_back('{247, 100, 1'b0, 1'b1, 1'b0, 1'b0, -1});
        tab48.push_back('{248, 100, 1'b0, 1'b1, 1'b0, 1'b1, -1});
        tab48.push_back('{251, 100, 1'b0, 1'b1, 1'b0, 1'b1, -1});
        tab48.push_back('{252, 100, 1'b0, 1'b1, 1'b0, 1'b0, -1});
        tab48.push_back('{271, 0, 1'b0, 1'b1, 1'b0, 1'b0, -1});
        tab48.push_back('{272, 0, 1'b0, 1'b0, 1'b0, 1'b0, -1});
        tab48.push_back('{311, 447, 1'b0, 1'b0, 1'b0, 1'b0, -1});

        // S128 frame points; Pentagon selected mid-frame must not act yet
        tab128.push_back('{0, 455, 1'b0, 1'b0, 1'b0, 1'b0, -1});
        tab128.push_back('{100, 0, 1'b1, 1'b0, 1'b0, 1'b0, int'(PENTAGON)});
        tab128.push_back('{191, 5, 1'b1, 1'b0, 1'b0, 1'b0, -1});
        tab128.push_back('{310, 455, 1'b0, 1'b0, 1'b0, 1'b0, -1});

        edges = 0; last_fs_edge = 0; fs_period = 0; fs_cnt = 0;
        clear_stats();

        // Reset state
        rst         = 1'b1;
        vif.ck7     = 1'b0;
        vif.machine = S48;
        repeat (3) @(posedge clk28);
        #1;
        check_zero("reset");

        // Counters hold without ck7, step only on strobe edges
        rst = 1'b0;
        step(); step();
        check("hold hc", vif.hc, 0);
        vif.ck7 = 1'b1;
        step();
        check("first strobe hc", vif.hc, 1);
        for (int g = 0; g < 3; g++) begin
            vif.ck7 = 1'b1;
            step();
            vif.ck7 = 1'b0;
            check($sformatf("strobe%0d hc", g), vif.hc, 2 + g);
            check($sformatf("strobe%0d cont", g), vif.screen_contention, 1);
            step(); step(); step();
            check($sformatf("gap%0d hc", g), vif.hc, 2 + g);
        end

        // Fresh start for the full-frame walk, ck7 held high
        rst = 1'b1;
        @(posedge clk28);
        #1;
        rst = 1'b0;
        edges = 0; last_fs_edge = 0; fs_cnt = 0;
        clear_stats();
        vif.ck7 = 1'b1;

        run_table("s48", tab48);
        check("s48 fs before wrap", fs_cnt, 0);
        step();
        check("s48 wrap hc", vif.hc, 0);
        check("s48 wrap vc", vif.vc, 0);
        check("s48 frame_start", vif.frame_start, 1);
        check("s48 line_start", vif.line_start, 1);
        check("s48 fs count", fs_cnt, 1);
        check("s48 edges", edges, 448 * 312);
        check("s48 hc peak", hc_max, 447);
        check("s48 vc peak", vc_max, 311);
        check("s48 lines", ls_cnt, 312);
        check("s128 latched cont", vif.screen_contention, 1);
        clear_stats();
        step();
        check("fs pulse width", vif.frame_start, 0);
        check("ls pulse width", vif.line_start, 0);
        check("s128 hc after wrap", vif.hc, 1);

        run_table("s128", tab128);
        step();
        check("s128 frame_start", vif.frame_start, 1);
        check("s128 wrap hc", vif.hc, 0);
        check("s128 wrap vc", vif.vc, 0);
        check("s128 period", fs_period, 456 * 311);
        check("s128 hc peak", hc_max, 455);
        check("s128 vc peak", vc_max, 310);
        check("s128 lines", ls_cnt, 311);
        check("pent latched cont", vif.screen_contention, 0);
        clear_stats();

        seek(319, 447);
        step();
        check("pent frame_start", vif.frame_start, 1);
        check("pent period", fs_period, 448 * 320);
        check("pent hc peak", hc_max, 447);
        check("pent vc peak", vc_max, 319);
        check("pent lines", ls_cnt, 320);
        check("pent cont count", cont_cnt, 0);

        // Asynchronous reset mid-frame
        seek(150, 200);
        fs_cnt = 0;
        vif.machine = S48;
        #2;
        rst = 1'b1;
        #1;
        check_zero("async rst");
        step(); step();
        check("rst hold hc", vif.hc, 0);
        check("rst no frame_start", fs_cnt, 0);
        rst = 1'b0;
        step();
        check("post rst hc", vif.hc, 1);
        check("post rst vc", vif.vc, 0);
        seek(10, 5);
        check("rst latched s48 cont", vif.screen_contention, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
